// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial front end feeding the sequence detector.
package seq_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word handshake on the parallel side plus the qualified serial stream on the other.
interface bit_serializer_if #(
  parameter int WIDTH = seq_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             seq_bit;
  logic             seq_valid;
  logic             busy;
  logic             word_done;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  seq_bit,
    input  seq_valid,
    input  busy,
    input  word_done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output seq_bit,
    output seq_valid,
    output busy,
    output word_done
  );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding buffer so consecutive words
// stream without an idle bit between them.
module bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic             clock,
  input logic             reset,
  bit_serializer_if.slave bus
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_full, hold_full_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CW-1:0]    cnt_inc;
  logic             seq_bit, seq_bit_nxt;
  logic             seq_valid, seq_valid_nxt;
  logic             word_done, word_done_nxt;
  logic             data_ready;
  logic             accept;
  logic             load_en;
  logic [WIDTH-1:0] load_word;

  // The word is never physically shifted; cnt selects which bit is on the wire.
  function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                    input logic [CW-1:0]    idx);
    logic [CW-1:0] pos;
    pos = MSB_FIRST ? (LAST - idx) : idx;
    return word[pos];
  endfunction

  assign data_ready = reset && !hold_full;
  assign accept     = bus.data_valid && data_ready;
  assign cnt_inc    = cnt + 1'b1;

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    cnt_nxt       = cnt;
    seq_bit_nxt   = seq_bit;
    seq_valid_nxt = seq_valid;
    word_done_nxt = 1'b0;
    load_en       = 1'b0;
    load_word     = bus.data_in;

    case (state)
      IDLE: begin
        if (accept) begin
          load_en   = 1'b1;
          load_word = bus.data_in;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          // Last bit retiring: refill from hold first, then from the port, else go idle.
          if (hold_full) begin
            load_en       = 1'b1;
            load_word     = hold;
            hold_full_nxt = 1'b0;
          end else if (accept) begin
            load_en   = 1'b1;
            load_word = bus.data_in;
          end else begin
            state_nxt     = IDLE;
            seq_bit_nxt   = IDLE_BIT;
            seq_valid_nxt = 1'b0;
          end
        end else begin
          cnt_nxt       = cnt_inc;
          seq_bit_nxt   = pick_bit(shreg, cnt_inc);
          word_done_nxt = (cnt_inc == LAST);
          if (accept) begin
            hold_nxt      = bus.data_in;
            hold_full_nxt = 1'b1;
          end
        end
      end
    endcase

    if (load_en) begin
      state_nxt     = SHIFT;
      shreg_nxt     = load_word;
      cnt_nxt       = '0;
      seq_bit_nxt   = pick_bit(load_word, '0);
      seq_valid_nxt = 1'b1;
      word_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      seq_bit   <= IDLE_BIT;
      seq_valid <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      cnt       <= cnt_nxt;
      seq_bit   <= seq_bit_nxt;
      seq_valid <= seq_valid_nxt;
      word_done <= word_done_nxt;
    end
  end

  assign bus.data_ready = data_ready;
  assign bus.seq_bit    = seq_bit;
  assign bus.seq_valid  = seq_valid;
  assign bus.busy       = seq_valid;
  assign bus.word_done  = word_done;

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end that feeds the sequence detector's 1-bit `sequence` input.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- A one-entry holding buffer allows back-to-back words to stream with no idle bit between them.
- `seq_valid` qualifies each bit so the downstream detector can ignore idle fill.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
- IDLE_BIT, 0, value driven on `sequence` when no word is being shifted.

Ports:
- clock       input   1      single system clock; all state updates on its rising edge.
- reset       input   1      synchronous, active-low; state clears at a rising clock edge while reset==0.
- data_in     input   WIDTH  parallel word to serialise.
- data_valid  input   1      data_in is valid this cycle.
- data_ready  output  1      block can accept a word; transfer occurs when data_valid && data_ready at a rising edge.
- sequence    output  1      serial bit stream; registered output.
- seq_valid   output  1      sequence carries a data bit (not idle fill); registered output.
- busy        output  1      shifter holds an in-flight word (equals seq_valid).
- word_done   output  1      high during the cycle that carries the last bit of a word; registered output.

Behaviour:
- Reset (reset==0 at an edge):
  - shifter, holding buffer and bit counter are cleared; state goes to IDLE.
  - Outputs: sequence=IDLE_BIT, seq_valid=0, busy=0, word_done=0.
  - data_ready is forced to 0 while reset==0; it is 1 in the first cycle after release.
  - Reset mid-word discards the shifter and buffer contents; no partial bits follow.
- Storage: shift register `shreg` (WIDTH bits), holding register `hold` with a `hold_full` flag, and counter `cnt` of $clog2(WIDTH) bits.
- data_ready = reset && !hold_full. This is combinational, with no dependence on data_valid.
- State IDLE (shifter empty):
  - On accept, the word loads directly into shreg and cnt resets to 0; the hold buffer is bypassed.
  - Next state is SHIFT.
- State SHIFT:
  - Each edge presents the next bit and increments cnt.
  - At the edge where the last bit retires (cnt==WIDTH-1):
    - If hold_full: hold moves to shreg, hold_full clears, state stays SHIFT, with no gap.
    - Else if a word is accepted at that same edge: it loads directly into shreg, with no gap.
    - Else: the next state is IDLE.
  - On accept while not at the last bit, the word goes to hold and hold_full is set.
- Latency: a word accepted at edge k appears on sequence at edges k..k+WIDTH-1. That is WIDTH consecutive cycles starting one register stage after the accept.
- Bit order: MSB_FIRST=1 emits data_in[WIDTH-1] first and data_in[0] last. MSB_FIRST=0 is the reverse.
- word_done is 1 exactly in the cycle the final bit of each word is on sequence.
- Holding buffer full with data_valid=1: the word is not accepted (data_ready=0) and the source must hold data_in stable. data_ready rises in the cycle after hold drains.
- Sustained throughput is one word per WIDTH cycles. The idle fill value never appears between back-to-back words.

Decomposition:
- Shared package `seq_pkg`:
  - state enum {IDLE, SHIFT};
  - localparam DEFAULT_WIDTH=8;
  - function to compute the counter width.
- No sub-module. The shifter, hold buffer and counter together are a single FSM in one module (about 150 lines of RTL).

Test Plan:
- Reset held low for 50 ns (20 ns clock), then released -> during reset sequence=0, seq_valid=0, data_ready=0; data_ready=1 in the first cycle after release.
- Single word, WIDTH=8: data_in=8'b0010_1100 accepted once -> sequence = 0,0,1,0,1,1,0,0 on 8 consecutive cycles with seq_valid=1, word_done only on the 8th cycle, then sequence=IDLE_BIT and seq_valid=0.
- Back-to-back: data_valid held high with words 8'hA5 then 8'h3C -> 16 contiguous valid bits 10100101_00111100 with no gap; data_ready drops to 0 after the second accept and rises once hold drains.
- Backpressure: offer three words continuously -> third accept is delayed until hold drains; no word is lost or duplicated; the 24-bit stream matches the concatenated words.
- Reset mid-word: assert reset after bit 3 of 8'hFF with hold also full -> at the next edge seq_valid=0 and sequence=0; after release, no leftover bits appear and data_ready=1.
- MSB_FIRST=0, data_in=8'b0000_0001 -> the first emitted bit is 1, followed by seven 0s.
